// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared widths, cache geometry default and fetch FSM encoding
package ifetch_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int ICACHE_IDX_W_DEFAULT = 6;

  typedef enum logic {
    LOOKUP    = 1'b0,
    MISS_WAIT = 1'b1
  } fetch_state_t;

  // Sequential PC step; wraps modulo 2^32 by truncation.
  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ifetch_icache.sv
// rtl/ifetch_icache.sv - direct-mapped one-word-per-line I-cache, async lookup, sync fill
module icache
  import ifetch_pkg::*;
#(
  parameter int IDX_W = ICACHE_IDX_W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [IDX_W-1:0]          rd_idx,
  input  logic [ADDR_W-IDX_W-3:0]   rd_tag,
  output logic                      hit,
  output logic [INST_W-1:0]         rd_data,
  input  logic                      wr_en,
  input  logic [IDX_W-1:0]          wr_idx,
  input  logic [ADDR_W-IDX_W-3:0]   wr_tag,
  input  logic [INST_W-1:0]         wr_data
);

  localparam int LINES = 1 << IDX_W;

  logic [LINES-1:0]          valid;
  logic [ADDR_W-IDX_W-3:0]   tag_mem  [LINES];
  logic [INST_W-1:0]         data_mem [LINES];

  assign hit     = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_data = data_mem[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: a line is only consulted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch: I-cache lookup, miss refill via memctrl, push to IQ
module ifetch
  import ifetch_pkg::*;
#(
  parameter int ICACHE_IDX_W = ICACHE_IDX_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              iJUMP_en,
  input  logic [ADDR_W-1:0] iJUMP_pc,
  output logic              oINF_en,
  output logic [ADDR_W-1:0] oINF_addr,
  input  logic              iINF_done,
  input  logic [INST_W-1:0] iINF_inst,
  input  logic              iIQ_full,
  output logic              oIQ_en,
  output logic [INST_W-1:0] oIQ_inst,
  output logic [ADDR_W-1:0] oIQ_pc
);

  fetch_state_t       state;
  logic [ADDR_W-1:0]  pc;
  logic               hit;
  logic [INST_W-1:0]  line_inst;
  logic               fill_en;

  // Fill targets the outstanding request address, not pc, so a redirect during a miss is safe.
  assign fill_en = !rst && rdy && (state == MISS_WAIT) && iINF_done;

  icache #(
    .IDX_W(ICACHE_IDX_W)
  ) u_icache (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (pc[ICACHE_IDX_W+1:2]),
    .rd_tag  (pc[ADDR_W-1:ICACHE_IDX_W+2]),
    .hit     (hit),
    .rd_data (line_inst),
    .wr_en   (fill_en),
    .wr_idx  (oINF_addr[ICACHE_IDX_W+1:2]),
    .wr_tag  (oINF_addr[ADDR_W-1:ICACHE_IDX_W+2]),
    .wr_data (iINF_inst)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOOKUP;
      pc        <= '0;
      oINF_en   <= 1'b0;
      oINF_addr <= '0;
      oIQ_en    <= 1'b0;
      oIQ_inst  <= '0;
      oIQ_pc    <= '0;
    end else begin
      oIQ_en <= 1'b0;
      if (!rdy) begin
        // Abandon an in-flight refill; LOOKUP will reissue it on resume.
        if (state == MISS_WAIT) begin
          oINF_en <= 1'b0;
          state   <= LOOKUP;
        end
      end else begin
        if (iJUMP_en) begin
          pc <= iJUMP_pc;
        end
        case (state)
          LOOKUP: begin
            if (!iJUMP_en) begin
              if (hit) begin
                if (!iIQ_full) begin
                  oIQ_en   <= 1'b1;
                  oIQ_inst <= line_inst;
                  oIQ_pc   <= pc;
                  pc       <= next_pc(pc);
                end
              end else begin
                oINF_en   <= 1'b1;
                oINF_addr <= pc;
                state     <= MISS_WAIT;
              end
            end
          end
          MISS_WAIT: begin
            if (iINF_done) begin
              oINF_en <= 1'b0;
              state   <= LOOKUP;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - scoreboard bench for ifetch with a bounded-latency memctrl responder
module tb_ifetch;

  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        iJUMP_en;
  logic [31:0] iJUMP_pc;
  logic        oINF_en;
  logic [31:0] oINF_addr;
  logic        iINF_done;
  logic [31:0] iINF_inst;
  logic        iIQ_full;
  logic        oIQ_en;
  logic [31:0] oIQ_inst;
  logic [31:0] oIQ_pc;

  int checks = 0;
  int failures = 0;
  int resp_allow = 0;
  int resp_given = 0;
  int cnt = 0;

  logic [63:0] exp_q[$];
  logic [31:0] req_q[$];
  logic        prev_en = 1'b0;
  logic [31:0] prev_addr = '0;

  always #5 clk = ~clk;

  ifetch #(.ICACHE_IDX_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .iJUMP_en  (iJUMP_en),
    .iJUMP_pc  (iJUMP_pc),
    .oINF_en   (oINF_en),
    .oINF_addr (oINF_addr),
    .iINF_done (iINF_done),
    .iINF_inst (iINF_inst),
    .iIQ_full  (iIQ_full),
    .oIQ_en    (oIQ_en),
    .oIQ_inst  (oIQ_inst),
    .oIQ_pc    (oIQ_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 8) | 32'h13;
  endfunction

  // memctrl: answers a held request LAT cycles later, only as many times as resp_allow grants
  initial begin
    iINF_done = 1'b0;
    iINF_inst = '0;
    forever begin
      @(negedge clk);
      iINF_done = 1'b0;
      if (oINF_en && rdy && !rst && (resp_given < resp_allow)) begin
        cnt++;
        if (cnt == LAT) begin
          iINF_done = 1'b1;
          iINF_inst = mem_word(oINF_addr);
          resp_given++;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && oIQ_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_push got inst=%h pc=%h want none", oIQ_inst, oIQ_pc);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({oIQ_inst, oIQ_pc} !== e) begin
          failures++;
          $display("FAIL push_data got inst=%h pc=%h want inst=%h pc=%h",
                   oIQ_inst, oIQ_pc, e[63:32], e[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (oINF_en && !prev_en) req_q.push_back(oINF_addr);
    if (oINF_en && prev_en) begin
      checks++;
      if (oINF_addr !== prev_addr) begin
        failures++;
        $display("FAIL inf_addr_stable got=%h want=%h", oINF_addr, prev_addr);
      end
    end
    prev_en   = oINF_en;
    prev_addr = oINF_addr;
  end

  task automatic wait_drain;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
  endtask

  task automatic pause_and_jump(input logic [31:0] target);
    rdy = 1'b0;
    @(negedge clk);
    rdy = 1'b1;
    iJUMP_en = 1'b1;
    iJUMP_pc = target;
    @(negedge clk);
    iJUMP_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; rdy = 1'b0; iJUMP_en = 1'b0; iJUMP_pc = '0; iIQ_full = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (oINF_en !== 1'b0) begin failures++; $display("FAIL reset_inf_en got=%b want=0", oINF_en); end
    checks++;
    if (oINF_addr !== 32'h0) begin failures++; $display("FAIL reset_inf_addr got=%h want=0", oINF_addr); end
    checks++;
    if (oIQ_en !== 1'b0) begin failures++; $display("FAIL reset_iq_en got=%b want=0", oIQ_en); end
    checks++;
    if (oIQ_inst !== 32'h0) begin failures++; $display("FAIL reset_iq_inst got=%h want=0", oIQ_inst); end
    checks++;
    if (oIQ_pc !== 32'h0) begin failures++; $display("FAIL reset_iq_pc got=%h want=0", oIQ_pc); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cold_start;
    exp_q.push_back({mem_word(32'h0), 32'h0});
    resp_allow += 1;
    rdy = 1'b1;
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL cold_push_timeout got pending=%0d want 0", exp_q.size()); end
    repeat (4) @(negedge clk);
    checks++;
    if (req_q.size() != 2 || req_q[0] !== 32'h0 || req_q[1] !== 32'h4) begin
      failures++;
      $display("FAIL cold_requests got n=%0d first=%h second=%h want n=2 0 4", req_q.size(), req_q[0], req_q[1]);
    end
  endtask

  task automatic test_warm_loop;
    exp_q.push_back({mem_word(32'h4), 32'h4});
    exp_q.push_back({mem_word(32'h8), 32'h8});
    exp_q.push_back({mem_word(32'hC), 32'hC});
    resp_allow += 3;
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL warm_fill_timeout got pending=%0d want 0", exp_q.size()); end
    repeat (4) @(negedge clk);
    req_q.delete();
    for (int a = 0; a < 16; a += 4) exp_q.push_back({mem_word(32'(a)), 32'(a)});
    pause_and_jump(32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (oIQ_en !== 1'b1) begin failures++; $display("FAIL warm_consecutive slot=%0d got=%b want=1", i, oIQ_en); end
    end
    wait_drain();
    repeat (4) @(negedge clk);
    checks++;
    if (req_q.size() != 1 || req_q[0] !== 32'h10) begin
      failures++;
      $display("FAIL warm_requests got n=%0d first=%h want n=1 10", req_q.size(), req_q[0]);
    end
  endtask

  task automatic test_backpressure;
    iIQ_full = 1'b1;
    pause_and_jump(32'h8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (oIQ_en !== 1'b0) begin failures++; $display("FAIL bp_stall cycle=%0d got=%b want=0", i, oIQ_en); end
    end
    exp_q.push_back({mem_word(32'h8), 32'h8});
    exp_q.push_back({mem_word(32'hC), 32'hC});
    iIQ_full = 1'b0;
    @(negedge clk);
    checks++;
    if (oIQ_en !== 1'b1) begin failures++; $display("FAIL bp_release got=%b want=1", oIQ_en); end
    wait_drain();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL bp_timeout got pending=%0d want 0", exp_q.size()); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_redirect_mid_miss;
    req_q.delete();
    pause_and_jump(32'h100);
    @(negedge clk);
    checks++;
    if (oINF_en !== 1'b1 || oINF_addr !== 32'h100) begin
      failures++;
      $display("FAIL mid_miss_issue got en=%b addr=%h want en=1 addr=100", oINF_en, oINF_addr);
    end
    iJUMP_en = 1'b1; iJUMP_pc = 32'h200;
    @(negedge clk);
    iJUMP_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (oINF_en !== 1'b1 || oINF_addr !== 32'h100) begin
        failures++;
        $display("FAIL mid_miss_hold got en=%b addr=%h want en=1 addr=100", oINF_en, oINF_addr);
      end
    end
    resp_allow += 1;
    for (int i = 0; i < 60 && req_q.size() < 2; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (req_q.size() != 2 || req_q[0] !== 32'h100 || req_q[1] !== 32'h200) begin
      failures++;
      $display("FAIL mid_miss_requests got n=%0d first=%h second=%h want n=2 100 200", req_q.size(), req_q[0], req_q[1]);
    end
  endtask

  task automatic test_alias_wrap;
    req_q.delete();
    exp_q.push_back({mem_word(32'h100), 32'h100});
    pause_and_jump(32'h100);
    wait_drain();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || req_q.size() != 1 || req_q[0] !== 32'h104) begin
      failures++;
      $display("FAIL filled_hit got pending=%0d n=%0d first=%h want 0 1 104", exp_q.size(), req_q.size(), req_q[0]);
    end
    req_q.delete();
    for (int a = 0; a < 16; a += 4) exp_q.push_back({mem_word(32'(a)), 32'(a)});
    pause_and_jump(32'h0);
    resp_allow += 1;
    wait_drain();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || req_q.size() != 2 || req_q[0] !== 32'h0 || req_q[1] !== 32'h10) begin
      failures++;
      $display("FAIL alias_replace got pending=%0d n=%0d first=%h second=%h want 0 2 0 10",
               exp_q.size(), req_q.size(), req_q[0], req_q[1]);
    end
    req_q.delete();
    exp_q.push_back({mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC});
    for (int a = 0; a < 16; a += 4) exp_q.push_back({mem_word(32'(a)), 32'(a)});
    pause_and_jump(32'hFFFF_FFFC);
    resp_allow += 1;
    wait_drain();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || req_q.size() != 2 || req_q[0] !== 32'hFFFF_FFFC || req_q[1] !== 32'h10) begin
      failures++;
      $display("FAIL wrap got pending=%0d n=%0d first=%h second=%h want 0 2 fffffffc 10",
               exp_q.size(), req_q.size(), req_q[0], req_q[1]);
    end
  endtask

  task automatic test_rdy_drop;
    req_q.delete();
    rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (oINF_en !== 1'b0) begin failures++; $display("FAIL rdy_pause cycle=%0d got=%b want=0", i, oINF_en); end
    end
    exp_q.push_back({mem_word(32'h10), 32'h10});
    resp_allow += 1;
    rdy = 1'b1;
    wait_drain();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || req_q.size() != 2 || req_q[0] !== 32'h10 || req_q[1] !== 32'h14) begin
      failures++;
      $display("FAIL rdy_reissue got pending=%0d n=%0d first=%h second=%h want 0 2 10 14",
               exp_q.size(), req_q.size(), req_q[0], req_q[1]);
    end
  endtask

  initial begin
    test_reset();
    test_cold_start();
    test_warm_loop();
    test_backpressure();
    test_redirect_mid_miss();
    test_alias_wrap();
    test_rdy_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
